// File: rtl/nibble_add_scheduler.sv
// nibble_add_scheduler: two requesters share one 4-bit ripple slice.
// A WIDTH-bit add is sequenced one nibble per cycle, with the carry registered between nibbles.
// A round-robin arbiter picks the requester, and a valid/ready channel returns the tagged result.
// Optional build macro NIBBLE_SUB_EN adds a per-requester subtract input i_req_sub.
module nibble_add_scheduler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [1:0]         i_req_valid,
  output logic [1:0]         o_req_ready,
  input  logic [2*WIDTH-1:0] i_req_a,
  input  logic [2*WIDTH-1:0] i_req_b,
  input  logic [1:0]         i_req_cin,
`ifdef NIBBLE_SUB_EN
  input  logic [1:0]         i_req_sub,
`endif
  output logic               o_res_valid,
  input  logic               i_res_ready,
  output logic [WIDTH-1:0]   o_res_sum,
  output logic               o_res_cout,
  output logic               o_res_id
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [KW-1:0]    r_k;
  logic             r_carry, r_cout, r_id, r_ptr;
  logic             r_sub;

  logic             w_any, w_grant, w_cin_sel, w_sub_sel, w_last, w_res_fire;
  logic [WIDTH-1:0] w_a_sel, w_b_sel;
  logic [KW+1:0]    w_shift;
  logic [3:0]       w_a_nib, w_b_nib, w_slice_sum;
  logic             w_slice_cout;
  logic             w_c;

  // Arbitration: sole valid requester wins, ptr breaks ties.
  assign w_any   = |i_req_valid;
  assign w_grant = (&i_req_valid) ? r_ptr : i_req_valid[1];

  assign w_a_sel   = w_grant ? i_req_a[2*WIDTH-1:WIDTH] : i_req_a[WIDTH-1:0];
  assign w_b_sel   = w_grant ? i_req_b[2*WIDTH-1:WIDTH] : i_req_b[WIDTH-1:0];
  assign w_cin_sel = w_grant ? i_req_cin[1] : i_req_cin[0];
`ifdef NIBBLE_SUB_EN
  assign w_sub_sel = w_grant ? i_req_sub[1] : i_req_sub[0];
`else
  assign w_sub_sel = 1'b0;
`endif

  // Nibble k sits at bit offset 4k.
  assign w_shift    = {r_k, 2'b00};
  assign w_a_nib    = 4'(r_a >> w_shift);
  assign w_b_nib    = 4'(r_b >> w_shift) ^ {4{r_sub}};
  assign w_last     = (r_k == KW'(NIB - 1));
  assign w_res_fire = (r_state == StDone) && i_res_ready;

  // The single shared 4-bit ripple-carry slice.
  always_comb begin
    w_c         = r_carry;
    w_slice_sum = 4'h0;
    for (int i = 0; i < 4; i++) begin
      w_slice_sum[i] = w_a_nib[i] ^ w_b_nib[i] ^ w_c;
      w_c            = (w_a_nib[i] & w_b_nib[i]) | (w_c & (w_a_nib[i] ^ w_b_nib[i]));
    end
    w_slice_cout = w_c;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_any) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  if (i_res_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    o_req_ready = 2'b00;
    o_res_valid = 1'b0;
    unique case (r_state)
      StIdle:  if (w_any) o_req_ready = w_grant ? 2'b10 : 2'b01;
      StDone:  o_res_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on grant, one nibble per RUN cycle, ptr flips on result handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_id    <= 1'b0;
      r_ptr   <= 1'b0;
      r_sub   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_a     <= w_a_sel;
            r_b     <= w_b_sel;
            r_sub   <= w_sub_sel;
            // Subtract forces carry-in to 1, so OR covers both modes.
            r_carry <= w_cin_sel | w_sub_sel;
            r_id    <= w_grant;
            r_k     <= '0;
          end
        end
        StRun: begin
          r_sum   <= (r_sum & ~(WIDTH'(4'hF) << w_shift)) | (WIDTH'(w_slice_sum) << w_shift);
          r_carry <= w_slice_cout;
          r_k     <= r_k + KW'(1);
          if (w_last) r_cout <= w_slice_cout;
        end
        StDone: begin
          if (w_res_fire) r_ptr <= ~r_id;
        end
        default: ;
      endcase
    end
  end

  assign o_res_sum  = r_sum;
  assign o_res_cout = r_cout;
  assign o_res_id   = r_id;

endmodule

// File: doc/nibble_add_scheduler.md
# nibble_add_scheduler

Shares one 4-bit `ripple_adder` slice between two requesters and sequences it nibble-serially to perform WIDTH-bit additions. A round-robin arbiter grants one requester at a time. The captured operands are fed through the slice one nibble per cycle, with the carry registered between nibbles. The result is returned on a valid/ready output channel tagged with the requester id. The block sits between the two arithmetic clients and the single shared adder resource.

## Interface
- `WIDTH`, 16: operand/result width; must be a multiple of 4 and ≥4. NIB = WIDTH/4.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: bit i = requester i has an operation pending.
- `req_ready` out 2: bit i = requester i's operands accepted this cycle (one-hot or zero).
- `req_a` in 2*WIDTH: operand A; requester i in bits [i*WIDTH +: WIDTH].
- `req_b` in 2*WIDTH: operand B, same packing.
- `req_cin` in 2: carry-in per requester.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts result.
- `res_sum` out WIDTH: sum.
- `res_cout` out 1: carry out of MSB nibble.
- `res_id` out 1: requester that issued the result.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any `req_valid` bit is set, grant g: the sole valid requester, or `ptr` when both are valid.
  - `req_ready[g]`=1 combinationally in that cycle.
  - On the edge, capture `req_a[g]`, `req_b[g]`, `req_cin[g]` and id=g; clear nibble index k=0; go to RUN.
- RUN:
  - Slice inputs are A[4k+3:4k], B[4k+3:4k] and the carry register. The carry register is loaded from the captured cin at acceptance.
  - Each edge writes the slice sum into `res_sum[4k+3:4k]`, stores the slice carry-out and increments k.
  - After nibble NIB-1, latch `res_cout` and go to DONE.
- DONE:
  - `res_valid`=1; `res_sum`, `res_cout` and `res_id` are held stable.
  - On `res_valid && res_ready`: `ptr` ← ~id, go to IDLE.
- `req_ready` is 0 in RUN and DONE; new requests wait, and their inputs must stay stable until accepted.
- Arithmetic: `res_sum` = (A + B + cin) mod 2^WIDTH; `res_cout` = bit WIDTH of the full sum. Only one slice instance exists; there is no other adder.
- Boundary conditions:
  - Both requests valid: grant goes to `ptr`; alternation is guaranteed because `ptr` flips to the other requester after each completed result.
  - A request deasserted before grant is simply not granted.
  - `res_ready` held at 0: remain in DONE indefinitely with outputs stable.
  - Reset mid-operation: state→IDLE, k, carry, `ptr`, `res_*` and `req_ready` all →0 immediately; the partial operation is discarded.

## Timing
- Reset values: `req_ready`=0, `res_valid`=0, `res_sum`=0, `res_cout`=0, `res_id`=0; internal `ptr`=0.
- Accept edge at cycle 0 → RUN cycles 1..NIB → `res_valid` high from cycle NIB+1 (cycle 5 for WIDTH=16).
- Back-to-back minimum period: NIB+2 cycles (the DONE handshake cycle, then IDLE accept cycle).
- Slice path: ripple_adder combinational, registered every cycle; no multicycle paths.

## Configuration
- `NIBBLE_SUB_EN` defined:
  - Adds input port `req_sub` (2 bits), captured at grant.
  - When `sub`=1, B nibbles are inverted before the slice and the initial carry is forced to 1; `req_cin` is ignored. Result is A − B mod 2^WIDTH, with `res_cout`=1 meaning no borrow.
- `NIBBLE_SUB_EN` undefined: port absent; add only.

## Test plan
- WIDTH=16, req0 a=0x1234 b=0x0FFF cin=0, `res_ready`=1 → `req_ready`=01 at cycle 0; `res_valid` at cycle 5 with sum=0x2233, cout=0, id=0.
- req1 a=0xFFFF b=0x0001 cin=0 → sum=0x0000, cout=1, id=1 (carry ripples through all four nibbles); a=0xFFFF b=0x0000 cin=1 gives the same result.
- Both requesters valid continuously from reset → grant order 0,1,0,1; `res_id` alternates across four results.
- `res_ready`=0 for 3 cycles in DONE → `res_valid`, `res_sum` and `res_cout` stable; `req_ready`=00 throughout; completes on the cycle `res_ready` rises.
- `rst_n` pulsed low during RUN cycle 2 → all outputs 0 asynchronously; after release with both valid, req0 is granted first.
- With `NIBBLE_SUB_EN`: a=0x0005 b=0x0007 sub=1 → sum=0xFFFE, cout=0; a=0x0007 b=0x0005 sub=1 → sum=0x0002, cout=1.
